axi_lite_copy_master: RTL

AXI_LITE_COPY_MASTER -- requirements
Module: axi_lite_copy_master

---
 rtl/axi_lite_copy_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_copy_master.sv
// Single-beat AXI-lite copy engine: reads len_words 64-bit words from src and writes them to dst, one transfer at a time.
// Optional running checksum of written words is enabled by defining AXI_LITE_COPY_CHECKSUM_EN.
module axi_lite_copy_master #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  // job control
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [31:0]             len_words,
  // status
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             words_done,
  // AXI-lite write channels
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // AXI-lite read channels
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
`ifdef AXI_LITE_COPY_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]   checksum
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AWW  = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] src_q,    src_d;
  logic [ADDR_WIDTH-1:0] dst_q,    dst_d;
  logic [31:0]           len_q,    len_d;
  logic [DATA_WIDTH-1:0] hold_q,   hold_d;
  logic [31:0]           words_q,  words_d;
  logic                  err_q,    err_d;
  // Per-channel pending flags let AW and W complete in any order.
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q,  w_pend_d;
`ifdef AXI_LITE_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q,    chk_d;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    hold_d    = hold_q;
    words_d   = words_q;
    err_d     = err_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
`ifdef AXI_LITE_COPY_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len_words;
          words_d = '0;
          err_d   = 1'b0;
`ifdef AXI_LITE_COPY_CHECKSUM_EN
          chk_d   = '0;
`endif
          if ((src_addr[2:0] != 3'd0) || (dst_addr[2:0] != 3'd0)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (len_words == 32'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (m_arready) state_d = S_R;
      end
      S_R: begin
        if (m_rvalid) begin
          hold_d = m_rdata;
          if (m_rresp == RESP_OKAY) begin
            state_d   = S_AWW;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_AWW: begin
        if (m_awready) aw_pend_d = 1'b0;
        if (m_wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_B;
      end
      S_B: begin
        if (m_bvalid) begin
          if (m_bresp == RESP_OKAY) begin
            words_d = words_q + 32'd1;
            src_d   = src_q + ADDR_WIDTH'(8);
            dst_d   = dst_q + ADDR_WIDTH'(8);
`ifdef AXI_LITE_COPY_CHECKSUM_EN
            chk_d   = chk_q + hold_q;
`endif
            state_d = ((words_q + 32'd1) == len_q) ? S_FIN : S_AR;
          end else begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      hold_q    <= '0;
      words_q   <= '0;
      err_q     <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
`ifdef AXI_LITE_COPY_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      hold_q    <= hold_d;
      words_q   <= words_d;
      err_q     <= err_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
`ifdef AXI_LITE_COPY_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  // All bus outputs decode from registered state, so they hold steady until handshake.
  assign m_arvalid  = (state_q == S_AR);
  assign m_araddr   = src_q;
  assign m_rready   = (state_q == S_R);
  assign m_awvalid  = (state_q == S_AWW) && aw_pend_q;
  assign m_awaddr   = dst_q;
  assign m_wvalid   = (state_q == S_AWW) && w_pend_q;
  assign m_wdata    = hold_q;
  assign m_wstrb    = m_wvalid ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
  assign m_bready   = (state_q == S_B);
  assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done       = (state_q == S_FIN);
  assign err        = err_q;
  assign words_done = words_q;
`ifdef AXI_LITE_COPY_CHECKSUM_EN
  assign checksum   = chk_q;
`endif

endmodule
